// File: rtl/rtc_read_sequencer_if.sv
// Bus bundle between the RTC read sequencer, its controller, the RTC chip
// and the output register bank. The sequencer takes the master view.
interface rtc_read_sequencer_if;
   // controller side
   logic       start;
   logic [5:0] n_regs;
   logic [7:0] rtc_addr_base;
   logic [5:0] bank_base;
   logic       busy;
   logic       done;
   // RTC multiplexed bus
   logic [7:0] rtc_data_in;
   logic [7:0] rtc_addr_out;
   logic       rtc_oe;
   logic       rtc_cs_n;
   logic       rtc_rd_n;
   logic       rtc_wr_n;
   logic       rtc_ad;
   // register bank write port
   logic [7:0] entrada;
   logic [5:0] enable;
   logic       w_s;

   modport master (
      input  start, n_regs, rtc_addr_base, bank_base, rtc_data_in,
      output busy, done, rtc_addr_out, rtc_oe, rtc_cs_n, rtc_rd_n,
             rtc_wr_n, rtc_ad, entrada, enable, w_s
   );

   modport slave (
      output start, n_regs, rtc_addr_base, bank_base, rtc_data_in,
      input  busy, done, rtc_addr_out, rtc_oe, rtc_cs_n, rtc_rd_n,
             rtc_wr_n, rtc_ad, entrada, enable, w_s
   );
endinterface

// File: rtl/rtc_read_sequencer.sv
// Reads a run of RTC registers over the multiplexed address/data bus and
// writes each byte into the register bank. Every output is registered and
// decoded from the current state, so pins lag the state register by one
// cycle; the phase counter accounts for that so each strobe is PULSE wide.
module rtc_read_sequencer #(
   parameter int unsigned PULSE = 4
) (
   input  logic          clk,
   input  logic          reset,
   rtc_read_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ADDR  = 3'd2,
      GAP   = 3'd3,
      DATA  = 3'd4,
      WRITE = 3'd5,
      FIN   = 3'd6
   } state_t;

   localparam logic [3:0] PHASE_LAST = 4'(PULSE - 1);
   localparam logic [6:0] BANK_TOP   = 7'h2F;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [5:0] k_q, k_d;
   logic [5:0] n_q, n_d;
   logic [7:0] abase_q, abase_d;
   logic [5:0] bbase_q, bbase_d;
   logic [6:0] idx_s;

   logic       cs_n_q, cs_n_d;
   logic       rd_n_q, rd_n_d;
   logic       wr_n_q, wr_n_d;
   logic       ad_q, ad_d;
   logic       oe_q, oe_d;
   logic       w_s_q, w_s_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] entrada_q, entrada_d;
   logic [5:0] enable_q, enable_d;
   logic [7:0] addr_q, addr_d;

   // Bank index is formed at 7 bits so running past the bank top is visible.
   assign idx_s = {1'b0, bbase_q} + {1'b0, k_q};

   // Next-state, operand latching and registered-output decode.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      n_d       = n_q;
      abase_d   = abase_q;
      bbase_d   = bbase_q;
      cs_n_d    = 1'b1;
      rd_n_d    = 1'b1;
      wr_n_d    = 1'b1;
      ad_d      = 1'b1;
      oe_d      = 1'b0;
      w_s_d     = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      entrada_d = entrada_q;
      enable_d  = enable_q;
      addr_d    = addr_q;

      case (state_q)
         IDLE: begin
            // done_q high means the visible FIN cycle, where start is ignored
            if (bus.start && !done_q) begin
               state_d = CHECK;
               k_d     = 6'd0;
               n_d     = bus.n_regs;
               abase_d = bus.rtc_addr_base;
               bbase_d = bus.bank_base;
            end else begin
               state_d = IDLE;
            end
         end
         CHECK: begin
            busy_d = 1'b1;
            if ((k_q == n_q) || (idx_s > BANK_TOP)) begin
               state_d = FIN;
            end else begin
               state_d = ADDR;
            end
         end
         ADDR: begin
            busy_d = 1'b1;
            cs_n_d = 1'b0;
            ad_d   = 1'b0;
            wr_n_d = 1'b0;
            oe_d   = 1'b1;
            addr_d = abase_q + {2'b00, k_q};
            if (cnt_q == PHASE_LAST) begin
               state_d = GAP;
            end else begin
               state_d = ADDR;
            end
         end
         GAP: begin
            busy_d  = 1'b1;
            state_d = DATA;
         end
         DATA: begin
            busy_d = 1'b1;
            cs_n_d = 1'b0;
            rd_n_d = 1'b0;
            if (cnt_q == PHASE_LAST) begin
               state_d = WRITE;
            end else begin
               state_d = DATA;
            end
         end
         WRITE: begin
            // rd_n is still low on the pins here: this edge samples the byte
            busy_d    = 1'b1;
            w_s_d     = 1'b1;
            enable_d  = idx_s[5:0];
            entrada_d = bus.rtc_data_in;
            k_d       = k_q + 6'd1;
            state_d   = CHECK;
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // phase counter restarts on every state entry
      if (state_d != state_q) begin
         cnt_d = 4'd0;
      end else begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // State, phase counter and latched operands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         k_q     <= 6'd0;
         n_q     <= 6'd0;
         abase_q <= 8'd0;
         bbase_q <= 6'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         n_q     <= n_d;
         abase_q <= abase_d;
         bbase_q <= bbase_d;
      end
   end

   // Output registers; reset releases the bus immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         ad_q      <= 1'b1;
         oe_q      <= 1'b0;
         w_s_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         entrada_q <= 8'd0;
         enable_q  <= 6'd0;
         addr_q    <= 8'd0;
      end else begin
         cs_n_q    <= cs_n_d;
         rd_n_q    <= rd_n_d;
         wr_n_q    <= wr_n_d;
         ad_q      <= ad_d;
         oe_q      <= oe_d;
         w_s_q     <= w_s_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         entrada_q <= entrada_d;
         enable_q  <= enable_d;
         addr_q    <= addr_d;
      end
   end

   assign bus.rtc_cs_n     = cs_n_q;
   assign bus.rtc_rd_n     = rd_n_q;
   assign bus.rtc_wr_n     = wr_n_q;
   assign bus.rtc_ad       = ad_q;
   assign bus.rtc_oe       = oe_q;
   assign bus.w_s          = w_s_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.entrada      = entrada_q;
   assign bus.enable       = enable_q;
   assign bus.rtc_addr_out = addr_q;

endmodule

// File: doc/rtc_read_sequencer.md
# rtc_read_sequencer

Bus master that reads a run of registers from the external RTC chip over its multiplexed address/data bus. It writes each byte into the output register bank through that bank's `entrada`/`enable`/`w_s` write port. It sits directly upstream of the register bank and downstream of the controller, which issues `start`. It replaces per-byte software bus toggling with a fixed-timing hardware sequence.

## Interface
- `PULSE`, default 4: cycles each bus strobe (`rtc_wr_n`, `rtc_rd_n`) is held low. Legal range is 2..15.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset. One clock domain only.
- `start` input 1: one-cycle request to begin a sequence. Ignored while `busy`=1.
- `n_regs` input 6: number of registers to read. Sampled on `start`.
- `rtc_addr_base` input 8: RTC address of the first register. Sampled on `start`.
- `bank_base` input 6: bank index of the first register. Sampled on `start`.
- `rtc_data_in` input 8: RTC bus read data.
- `rtc_addr_out` output 8: address driven onto the RTC bus.
- `rtc_oe` output 1: 1 when this block drives the bus (address phase only).
- `rtc_cs_n` output 1: RTC chip select, active low.
- `rtc_rd_n` output 1: RTC read strobe, active low.
- `rtc_wr_n` output 1: RTC write strobe, active low. Used to latch the address.
- `rtc_ad` output 1: 0 selects the address phase, 1 selects the data phase.
- `entrada` output 8: data to the bank.
- `enable` output 6: bank register index.
- `w_s` output 1: bank write strobe, one cycle wide.
- `busy` output 1: high from the cycle after `start` until `done`.
- `done` output 1: one-cycle pulse when the sequence ends.

## Operation
- Reset values:
  - `rtc_cs_n`, `rtc_rd_n`, `rtc_wr_n`, `rtc_ad` = 1.
  - `rtc_oe`, `w_s`, `busy`, `done` = 0.
  - `entrada`, `enable`, `rtc_addr_out` = 0.
  - FSM state = IDLE.
- Registers latched on `start`:
  - `k` = 0 (offset counter).
  - `n` = `n_regs`.
  - `abase` = `rtc_addr_base`.
  - `bbase` = `bank_base`.
- State IDLE: on `start`, go to CHECK.
- State CHECK:
  - If `k` == `n`, or `bbase`+`k` > 0x2F (compared at 7 bits, no wrap), go to FIN.
  - Otherwise go to ADDR.
- State ADDR, PULSE cycles:
  - `rtc_cs_n`=0, `rtc_ad`=0, `rtc_wr_n`=0, `rtc_oe`=1.
  - `rtc_addr_out` = (`abase`+`k`) mod 256.
- State GAP, 1 cycle:
  - `rtc_cs_n`=1, all strobes 1, `rtc_oe`=0 (bus turnaround).
  - `rtc_ad` goes to 1.
- State DATA, PULSE cycles:
  - `rtc_cs_n`=0, `rtc_ad`=1, `rtc_rd_n`=0, `rtc_oe`=0.
  - `rtc_data_in` is captured into `entrada` on the last cycle of the phase.
- State WRITE, 1 cycle:
  - `rtc_cs_n`=1, `rtc_rd_n`=1.
  - `w_s`=1, `enable`=`bbase`+`k`, `entrada` holds the captured byte.
  - Increment `k`, then go to CHECK.
- State FIN, 1 cycle: `done`=1 and `busy`=0 in the same cycle, then go to IDLE.
- `w_s` is 1 only in WRITE. The bank therefore never sees a write outside this state.
- `entrada` and `enable` hold their last values between writes.
- A single PULSE-wide phase counter (4 bits) times ADDR and DATA. It reloads on every state entry.

## Timing
- `start` is seen at edge 0. Then:
  - `busy`=1 from edge 1.
  - CHECK occupies edge 1.
  - ADDR begins at edge 2.
- Each register costs 2·PULSE+3 cycles: ADDR (PULSE) + GAP (1) + DATA (PULSE) + WRITE (1) + CHECK (1). For PULSE=4 this is 11 cycles.
- Full run length: `done` rises (2·PULSE+3)·m + 2 cycles after `start`, where m is the number of registers actually written.
- `n_regs`=0: CHECK at edge 1, `done` at edge 2, no bus activity and no `w_s`.
- `start` while `busy`: ignored. The latched operands are unaffected.
- `start` in the FIN cycle: ignored. A new `start` is accepted from the first IDLE cycle.
- RTC address wraps 0xFF→0x00. The bank index never wraps; the sequence truncates instead.
- `rtc_cs_n` is never low in two adjacent states without a GAP or WRITE between them.
- Reset asserted mid-operation:
  - All outputs return to their reset values immediately (asynchronously).
  - The bus is released, no `w_s` is issued, and no `done` is issued.
  - After release the block is in IDLE.

## Test plan
- Reset check: hold `reset`=0 for 3 cycles and sample all outputs. Every output matches its reset value; release, and `busy` stays 0.
- Two-register read: PULSE=4, `rtc_addr_base`=0x21, `bank_base`=0x05, `n_regs`=2, RTC model returns 0x45 then 0x30.
  - `rtc_addr_out` is 0x21 then 0x22, each with `rtc_wr_n` low exactly 4 cycles.
  - `w_s` pulses carry `enable`=0x05/`entrada`=0x45 and `enable`=0x06/`entrada`=0x30.
  - `done` arrives exactly 24 cycles after `start`.
- Truncation at bank top: `bank_base`=0x2E, `n_regs`=5. Exactly 2 writes occur (`enable`=0x2E, 0x2F), then `done`.
- Zero length: `n_regs`=0. `done` arrives 2 cycles after `start`; `rtc_cs_n` and `w_s` never toggle.
- Address wrap plus ignored start: `rtc_addr_base`=0xFF, `n_regs`=2, and a second `start` is pulsed mid-run.
  - Addresses are 0xFF then 0x00.
  - Exactly 2 writes and one `done` occur.
- Reset mid-DATA: assert `reset` during the `rtc_rd_n`-low phase.
  - `rtc_rd_n`/`rtc_cs_n` go high within the same cycle.
  - No `w_s` and no `done` are issued.
  - A subsequent `start` runs normally.
